// File: rtl/divider_ctrl.sv
// divider_ctrl: sequencing FSM for the 8-bit non-restoring divider datapath.
// Issues load / shift / add-sub / count / final-correction strobes in a fixed
// order, pulses done once per operation and flags divide-by-zero without
// touching the datapath.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a new start request
// LOAD   | datapath loads R=0, Q=dividend; iteration counter cleared
// SHIFT  | shift R:Q left; remember the pre-shift remainder sign
// ADDSUB | add or subtract divisor based on the remembered sign
// FIX    | final remainder correction when the remainder is negative
// ERR    | divisor was zero; no datapath activity
// DONE   | one-cycle completion pulse
module divider_ctrl #(
  parameter int ITER = 8,
  parameter int CW   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic divisor_zero,
  input  logic rem_sign,
  output logic ready,
  output logic busy,
  output logic load,
  output logic shift_en,
  output logic add_en,
  output logic sub_en,
  output logic count_en,
  output logic final_add,
  output logic done,
  output logic div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_ADDSUB,
    S_FIX,
    S_ERR,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_iter;
  logic          r_sign_q;
  logic          r_dbz;
  logic          w_accept;
  logic          w_last;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_iter == LAST_ITER);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Iteration counter, captured remainder sign and sticky zero-divisor flag.
  // The flag is written with divisor_zero on every accepted start, so an
  // accepted zero-divisor request sets it on the edge that enters ERR.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_iter   <= '0;
      r_sign_q <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      if (r_state == S_LOAD) begin
        r_iter <= '0;
      end else if (r_state == S_ADDSUB && !w_last) begin
        r_iter <= r_iter + CW'(1);
      end
      if (r_state == S_SHIFT) begin
        r_sign_q <= rem_sign;
      end
      if (w_accept) begin
        r_dbz <= divisor_zero;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = divisor_zero ? S_ERR : S_LOAD;
      S_LOAD:   w_next = S_SHIFT;
      S_SHIFT:  w_next = S_ADDSUB;
      S_ADDSUB: w_next = w_last ? S_FIX : S_SHIFT;
      S_FIX:    w_next = S_DONE;
      S_ERR:    w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output strobes decoded from the registered state; only the add/sub
  // choice and the final correction gate look at data.
  always_comb begin
    ready       = 1'b0;
    busy        = 1'b0;
    load        = 1'b0;
    shift_en    = 1'b0;
    add_en      = 1'b0;
    sub_en      = 1'b0;
    count_en    = 1'b0;
    final_add   = 1'b0;
    done        = 1'b0;
    div_by_zero = r_dbz;
    case (r_state)
      S_IDLE:   ready = 1'b1;
      S_LOAD: begin
        busy = 1'b1;
        load = 1'b1;
      end
      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      S_ADDSUB: begin
        busy     = 1'b1;
        add_en   = r_sign_q;
        sub_en   = !r_sign_q;
        count_en = 1'b1;
      end
      S_FIX: begin
        busy      = 1'b1;
        final_add = rem_sign;
      end
      S_ERR:    busy = 1'b1;
      S_DONE:   done = 1'b1;
      default:  ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// tb_divider_ctrl: directed bench for divider_ctrl with a small behavioral
// non-restoring datapath that feeds rem_sign back to the controller.
module tb_divider_ctrl;

  logic clk = 1'b0;
  logic reset, start, divisor_zero, rem_sign;
  logic ready, busy, load, shift_en, add_en, sub_en, count_en;
  logic final_add, done, div_by_zero;

  int n_total = 0;
  int n_bad   = 0;

  // Output vector bit order:
  // [9]ready [8]busy [7]load [6]shift [5]add [4]sub [3]count [2]final_add [1]done [0]dbz
  localparam logic [9:0] IDLE_V = 10'b10_0000_0000;

  logic [9:0] trace [0:40];
  logic       m_sign [0:40];
  logic [7:0] m_r, m_q, m_a, m_d;
  logic       use_model;
  logic [40:0] smask;
  int         cnt;

  divider_ctrl #(.ITER(8), .CW(3)) dut (
    .clk(clk), .reset(reset), .start(start), .divisor_zero(divisor_zero),
    .rem_sign(rem_sign), .ready(ready), .busy(busy), .load(load),
    .shift_en(shift_en), .add_en(add_en), .sub_en(sub_en),
    .count_en(count_en), .final_add(final_add), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] obs();
    return {ready, busy, load, shift_en, add_en, sub_en, count_en,
            final_add, done, div_by_zero};
  endfunction

  // Expected outputs at cycle k of a normal operation accepted at edge 0.
  function automatic logic [9:0] exp_norm(input int k, input logic [7:0] addpat,
                                          input logic fa);
    logic [9:0] v;
    logic [7:0] t;
    v = '0;
    if (k == 1) begin
      v[8] = 1'b1; v[7] = 1'b1;
    end else if (k >= 2 && k <= 17 && (k % 2) == 0) begin
      v[8] = 1'b1; v[6] = 1'b1;
    end else if (k >= 3 && k <= 17) begin
      t = addpat >> ((k - 3) / 2);
      v[8] = 1'b1; v[5] = t[0]; v[4] = !t[0]; v[3] = 1'b1;
    end else if (k == 18) begin
      v[8] = 1'b1; v[2] = fa;
    end else if (k == 19) begin
      v[1] = 1'b1;
    end else if (k >= 20) begin
      v[9] = 1'b1;
    end
    return v;
  endfunction

  // Datapath register update for the strobes seen during one cycle.
  task automatic model_step(input logic [9:0] s);
    if (s[7]) begin
      m_r = 8'd0; m_q = m_a;
    end else if (s[6]) begin
      {m_r, m_q} = {m_r, m_q} << 1;
    end else if (s[5]) begin
      m_r = m_r + m_d; m_q[0] = ~m_r[7];
    end else if (s[4]) begin
      m_r = m_r - m_d; m_q[0] = ~m_r[7];
    end else if (s[2]) begin
      m_r = m_r + m_d;
    end
  endtask

  // Entered at a falling edge (cycle 0). Records outputs of cycles 0..ncyc.
  task automatic run_op(input logic dz, input logic [40:0] sm, input int ncyc,
                        input int rst_cyc);
    rem_sign  = use_model ? m_r[7] : 1'b0;
    trace[0]  = obs();
    m_sign[0] = m_r[7];
    for (int k = 0; k < ncyc; k++) begin
      start        = sm[k];
      divisor_zero = dz;
      reset        = (k == rst_cyc);
      @(posedge clk);
      #1;
      model_step(trace[k]);
      rem_sign = use_model ? m_r[7] : 1'b0;
      start    = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      trace[k+1]  = obs();
      m_sign[k+1] = m_r[7];
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; divisor_zero = 1'b0; rem_sign = 1'b0;
    use_model = 1'b0; m_a = 8'd100; m_d = 8'd7; m_r = '0; m_q = '0;

    // Reset held two cycles, then idle.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", i), 32'(obs()), 32'(IDLE_V));
    end

    // Fixed strobe sequence with rem_sign held low.
    run_op(1'b0, 41'b1, 21, -1);
    for (int k = 1; k <= 20; k++)
      chk($sformatf("seq_c%0d", k), 32'(trace[k]), 32'(exp_norm(k, 8'h00, 1'b0)));

    // 100 / 7 through the behavioral datapath.
    // Iteration ops: sub,add,add,add,add,sub,sub,sub; final R=-5 -> correction.
    use_model = 1'b1;
    run_op(1'b0, 41'b1, 21, -1);
    for (int k = 1; k <= 20; k++)
      chk($sformatf("div_c%0d", k), 32'(trace[k]), 32'(exp_norm(k, 8'b0001_1110, 1'b1)));
    for (int i = 0; i < 8; i++)
      chk($sformatf("addsel%0d", i), 32'(trace[3+2*i][5]), 32'(m_sign[2+2*i]));
    chk("fix_gate", 32'(trace[18][2]), 32'(m_sign[18]));
    chk("quot", 32'(m_q), 32'd14);
    chk("rem", 32'(m_r), 32'd2);
    use_model = 1'b0;

    // Divide by zero.
    run_op(1'b1, 41'b1, 4, -1);
    chk("dz_c1", 32'(trace[1]), 32'(10'b01_0000_0001));
    chk("dz_c2", 32'(trace[2]), 32'(10'b00_0000_0011));
    chk("dz_c3", 32'(trace[3]), 32'(10'b10_0000_0001));

    // Next valid start clears the flag.
    run_op(1'b0, 41'b1, 21, -1);
    chk("dz_hold", 32'(trace[0][0]), 32'd1);
    for (int k = 1; k <= 20; k++)
      chk($sformatf("clr_c%0d", k), 32'(trace[k]), 32'(exp_norm(k, 8'h00, 1'b0)));

    // Start pulses while busy and during DONE are ignored.
    smask = '0; smask[0] = 1'b1; smask[5] = 1'b1; smask[19] = 1'b1;
    run_op(1'b0, smask, 21, -1);
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      chk($sformatf("busy_c%0d", k), 32'(trace[k]), 32'(exp_norm(k, 8'h00, 1'b0)));
      if (trace[k][7]) cnt++;
    end
    chk("one_load", 32'(cnt), 32'd1);

    // Reset in cycle 10, then a clean operation.
    run_op(1'b0, 41'b1, 21, 10);
    for (int k = 1; k <= 10; k++)
      chk($sformatf("rst_c%0d", k), 32'(trace[k]), 32'(exp_norm(k, 8'h00, 1'b0)));
    for (int k = 11; k <= 20; k++)
      chk($sformatf("rst_idle%0d", k), 32'(trace[k]), 32'(IDLE_V));
    run_op(1'b0, 41'b1, 21, -1);
    for (int k = 1; k <= 20; k++)
      chk($sformatf("after_c%0d", k), 32'(trace[k]), 32'(exp_norm(k, 8'h00, 1'b0)));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/divider_ctrl.md
# divider_ctrl

Sequencing FSM for the 8-bit non-restoring divider datapath. It accepts a start request, then issues the load, shift, add/subtract, count and final-correction strobes in the fixed order the datapath needs. It reports completion with a one-cycle `done` pulse and flags divide-by-zero without running the datapath. It sits between the ALU top-level opcode decode and the divider, one instance per divider.

## Interface
- `ITER`, default 8: number of shift/add-sub iterations; equals the dividend width.
- `CW`, default 3: iteration counter width; must satisfy 2^CW >= ITER.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a division; accepted only when `ready`=1.
- `divisor_zero` in 1: divisor == 0, sampled in the cycle `start` is accepted.
- `rem_sign` in 1: sign bit of the datapath partial remainder R (R[7]).
- `ready` out 1: FSM in IDLE and able to accept `start`.
- `busy` out 1: operation in progress (any state other than IDLE or DONE).
- `load` out 1: load dividend/divisor; datapath sets R=0 and Q=dividend.
- `shift_en` out 1: shift R:Q left by one.
- `add_en` out 1: R <= R + divisor.
- `sub_en` out 1: R <= R - divisor.
- `count_en` out 1: datapath counter increment.
- `final_add` out 1: remainder correction, R <= R + divisor.
- `done` out 1: one-cycle completion pulse.
- `div_by_zero` out 1: sticky error flag for the last accepted operation.

## Operation
- States:
  - IDLE: `ready`=1; on `start`, go to ERR if `divisor_zero`, else LOAD.
  - LOAD: assert `load`; clear `iter`; go to SHIFT.
  - SHIFT: assert `shift_en`; capture `rem_sign` (the sign before the shift) into `sign_q`; go to ADDSUB.
  - ADDSUB: assert `add_en` if `sign_q`=1, otherwise `sub_en`; assert `count_en`. If `iter`==ITER-1, go to FIX; otherwise increment `iter` and go to SHIFT.
  - FIX: assert `final_add` only if `rem_sign`=1; the state always lasts exactly one cycle. Go to DONE.
  - ERR: no datapath strobes; set `div_by_zero`; go to DONE.
  - DONE: `done`=1; go to IDLE.
- At most one of `load`, `shift_en`, `add_en`, `sub_en`, `final_add` is high in any cycle.
- `count_en` is high only together with `add_en` or `sub_en`.
- `div_by_zero`:
  - cleared when any `start` is accepted;
  - set on entry to ERR;
  - otherwise holds its value.
- `start` while not in IDLE is ignored. It is not queued.
- Strobes are registered-state decodes. Only the `add_en`/`sub_en` choice (from `sign_q`) and the `final_add` gate (from `rem_sign`) depend on data.

## Timing
- Reset (synchronous): on the next edge, state=IDLE, `iter`=0, `sign_q`=0, `div_by_zero`=0.
  - Output values after reset: `ready`=1; every other output is 0.
- Normal operation, with `start` accepted at edge 0:
  - cycle 1: LOAD;
  - cycles 2..17: alternating SHIFT/ADDSUB, 8 pairs;
  - cycle 18: FIX;
  - cycle 19: DONE (`done`=1);
  - cycle 20: IDLE (`ready`=1).
- The latency is fixed at 19 cycles from start to `done`, independent of the data.
- Divide-by-zero: cycle 1 ERR, cycle 2 DONE with `done`=1 and `div_by_zero`=1, cycle 3 IDLE. No datapath strobe fires.
- `busy` is high in cycles 1..18 of a normal operation and in cycle 1 of an error operation.
- Back-to-back: the earliest next `start` is accepted in the first IDLE cycle after DONE. A `start` held high continuously therefore restarts every 20 cycles.
- Reset mid-operation (any state, including FIX or DONE): IDLE on the next edge. No further strobes, no `done` pulse, flag cleared.
- `rem_sign` is sampled combinationally in FIX and registered in SHIFT. The datapath must present it from its register output, never from combinational next-state logic.

## Test plan
- Reset then idle: hold `reset` 2 cycles, then `start`=0 for 10 cycles. Required: `ready`=1 and all strobes, `done`, `busy` and `div_by_zero` stay 0 throughout.
- Strobe sequence: `start` with `divisor_zero`=0 and `rem_sign` forced 0. Required:
  - `load` at cycle 1, `shift_en` at 2,4,…,16, `sub_en`+`count_en` at 3,5,…,17;
  - no `add_en`, no `final_add`, `done` only at cycle 19.
- Data-dependent ops: bench drives `rem_sign` from a behavioral non-restoring model for 100/7. Required:
  - the `add_en`/`sub_en` pattern matches the model;
  - `final_add` fires iff the model's final R < 0;
  - the model ends with Q=14, R=2.
- Divide-by-zero: `start` with `divisor_zero`=1. Required: `done` at cycle 2 with `div_by_zero`=1 and no strobes. The next valid `start` clears `div_by_zero` at cycle 1.
- Busy rejection: pulse `start` at cycles 5 and 19 of a running operation. Required: no restart, `done` still at cycle 19, exactly one `load`.
- Reset mid-op: assert `reset` in cycle 10. Required: IDLE at cycle 11, no `done`, no further strobes; a new `start` then completes normally in 19 cycles.
